ahb_slave_mem_model: RTL and testbench
======================================

Name: ahb_slave_mem_model

Overview:
Parametrised AHB-Lite slave memory model for simulation benches and on-chip scratch memory, generalised from the fixed 32-bit slave model. Adds configurable data width, programmable wait states, byte-lane writes from HSIZE, range-based error injection, write-to-read forwarding, and transfer/error counters. It sits behind the AHB-Lite interconnect as one decoded slave.

Parameters:
AWIDTH, 12, HADDR width in bits (byte address).
DWIDTH, 32, data bus width; legal values are 32 or 64.
DEPTH, 1024, memory depth in DWIDTH-wide words; must be at most 2^(AWIDTH-log2(DWIDTH/8)).
WWIDTH, 4, width of the wait-state config field; maximum wait is 2^WWIDTH-1.
CNT_WIDTH, 16, width of the status counters.

Ports:
HCLK  in  1  single clock; all logic is on the rising edge.
HRESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select.
HADDR  in  AWIDTH  byte address.
HWRITE  in  1  1 = write.
HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
HSIZE  in  3  transfer size, log2 of bytes.
HBURST  in  3  sampled only, no effect.
HMASTLOCK  in  1  sampled only, no effect.
HPROT  in  4  sampled only, no effect.
HWDATA  in  DWIDTH  write data, valid in the data phase.
HREADY  in  1  bus-level ready, HREADYIN equivalent.
HRDATA  out  DWIDTH  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.
CFG_WAIT  in  WWIDTH  wait states per accepted transfer.
CFG_ERR_EN  in  1  enables error-range injection.
CFG_ERR_BASE  in  AWIDTH  error range base address.
CFG_ERR_MASK  in  AWIDTH  error range compare mask.
ACC_COUNT  out  CNT_WIDTH  completed OKAY transfers.
ERR_COUNT  out  CNT_WIDTH  ERROR responses issued.

Behaviour:
- Reset (synchronous, HRESET=1 at an edge):
  - HREADYOUT=1, HRESP=0, HRDATA=0, ACC_COUNT=0, ERR_COUNT=0, state=IDLE.
  - Any pending transfer is discarded and its write is not committed.
  - Memory contents are not cleared.
- Accept condition: HSEL & HREADY & HTRANS[1] at a rising edge. On accept, latch address, HWRITE, HSIZE, wait count = CFG_WAIT, and the error decision.
- Unaccepted cases:
  - IDLE and BUSY are not accepted.
  - If either occurs while the slave is idle, the slave gives a zero-wait OKAY response (HREADYOUT=1, HRESP=0).
- Error decision, evaluated in the address phase. Any one of these makes the transfer an error:
  - HSIZE > log2(DWIDTH/8).
  - HADDR not aligned to the HSIZE.
  - Word index >= DEPTH.
  - CFG_ERR_EN=1 and ((HADDR ^ CFG_ERR_BASE) & CFG_ERR_MASK)==0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE:
  - Accept with error → ERR1.
  - Accept with no error and wait>0 → WAIT.
  - Accept with no error and wait=0 → DATA.
- WAIT: HREADYOUT=0, HRESP=0; decrement the wait count; when it reaches 1, next state is DATA.
- DATA (data phase completes this cycle):
  - Outputs HREADYOUT=1, HRESP=0.
  - Write: commit enabled byte lanes of HWDATA at the closing edge.
  - Read: HRDATA holds the addressed word.
  - A new accept in this cycle is pipelined, with the same transitions as from IDLE; otherwise → IDLE.
- ERR1: HREADYOUT=0, HRESP=1 → ERR2.
- ERR2:
  - Outputs HREADYOUT=1, HRESP=1.
  - Any write is suppressed and ERR_COUNT increments.
  - A new accept here is ignored; the master must cancel to IDLE per AHB-Lite.
  - → IDLE.
- Byte lanes: little-endian; lane mask = ((1<<(1<<HSIZE))-1) << HADDR[log2(DWIDTH/8)-1:0].
- HRDATA:
  - Reads always return the full word.
  - HRDATA is registered, and loaded at the edge entering DATA for a read.
  - It holds its value otherwise.
- Forwarding: when a read is accepted in the same cycle a write to the same word commits, HRDATA = write bytes merged over the memory word. There is no stale data.
- Counters:
  - ACC_COUNT increments on each DATA completion.
  - ERR_COUNT increments on each ERR2.
  - Both saturate at all-ones and do not wrap.
- CFG_* is sampled only at accept. Changes mid-transfer do not affect that transfer.
- HREADY=0 with HSEL=1 while the slave is idle: no accept, outputs hold.

Decomposition:
- Package ahb_slave_mem_pkg holds:
  - HTRANS and HRESP encodings.
  - FSM state enum.
  - The lane-mask function.
  - A size-legal function.
- One sub-module, ahb_slave_mem_ram: a DEPTH×DWIDTH array with a byte-enable write port and an asynchronous read port. The forwarding mux stays in the top level.

Test Plan:
- Zero-wait write then read: CFG_WAIT=0; write 0xDEADBEEF to 0x010, then read 0x010 → HRDATA=0xDEADBEEF, HREADYOUT never low, ACC_COUNT=2.
- Wait states: CFG_WAIT=3; read 0x020 → HREADYOUT low for exactly 3 cycles, then high with data.
- Byte lanes and forwarding:
  - Word 0x000=0x11223344; byte write 0xAA to 0x002 (HSIZE=0), followed by a back-to-back read of 0x000 → 0x11AA3344.
- Error injection: CFG_ERR_EN=1, BASE=0x100, MASK=0xF00; write to 0x104 → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (1,1); the memory is unchanged and ERR_COUNT=1.
- Illegal access: HSIZE=3 with DWIDTH=32 → two-cycle ERROR. A halfword at 0x001 → ERROR. Address with word index = DEPTH → ERROR.
- Reset mid-operation: CFG_WAIT=5; write accepted, HRESET asserted in the 2nd wait cycle → next cycle HREADYOUT=1, HRESP=0, the word is not written, counters are 0.

Source files
------------

// File: rtl/ahb_slave_mem_pkg.sv
// Shared encodings, FSM state type and address helpers for the AHB-Lite slave memory model.
package ahb_slave_mem_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  // Little-endian byte-lane mask for a transfer of 2^size bytes at lane offset off.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = (16'd1 << (16'd1 << size)) - 16'd1;
    return 8'(m << off);
  endfunction

  function automatic logic size_legal(input logic [2:0] size, input int unsigned lb);
    return 32'(size) <= lb;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_ram.sv
// Word-organised storage with a byte-enable write port and an asynchronous read port.
module ahb_slave_mem_ram #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IW     = 10
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [DWIDTH/8-1:0] be_i,
  input  logic [IW-1:0]       waddr_i,
  input  logic [DWIDTH-1:0]   wdata_i,
  input  logic [IW-1:0]       raddr_i,
  output logic [DWIDTH-1:0]   rdata_o
);

  localparam int unsigned NB = DWIDTH / 8;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem_model.sv
// AHB-Lite slave memory: programmable wait states, byte-lane writes, error-range injection,
// write-to-read forwarding and saturating transfer/error counters.
module ahb_slave_mem_model
  import ahb_slave_mem_pkg::*;
#(
  parameter int unsigned AWIDTH    = 12,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned WWIDTH    = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [AWIDTH-1:0]    HADDR,
  input  logic                 HWRITE,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic                 HMASTLOCK,
  input  logic [3:0]           HPROT,
  input  logic [DWIDTH-1:0]    HWDATA,
  input  logic                 HREADY,
  output logic [DWIDTH-1:0]    HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP,
  input  logic [WWIDTH-1:0]    CFG_WAIT,
  input  logic                 CFG_ERR_EN,
  input  logic [AWIDTH-1:0]    CFG_ERR_BASE,
  input  logic [AWIDTH-1:0]    CFG_ERR_MASK,
  output logic [CNT_WIDTH-1:0] ACC_COUNT,
  output logic [CNT_WIDTH-1:0] ERR_COUNT
);

  localparam int unsigned NB = DWIDTH / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e                state_q, state_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [WWIDTH-1:0]     wait_q, wait_d;
  logic [DWIDTH-1:0]     hrdata_q, hrdata_d;
  logic [CNT_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  err_q, err_d;

  logic                  accept;
  logic                  acc_err;
  logic                  load_rd;
  logic [LB-1:0]         size_off_mask;
  logic [IW-1:0]         idx_in, idx_q, rd_idx;
  logic                  ram_we;
  logic [NB-1:0]         be;
  logic [DWIDTH-1:0]     mem_rdata, rd_word;

  logic unused_bus;
  assign unused_bus = ^{HBURST, HMASTLOCK, HPROT};

  assign accept = HSEL && HREADY && (HTRANS == HtransNonseq || HTRANS == HtransSeq);

  // Address-phase error decision; any one condition turns the transfer into an ERROR.
  assign size_off_mask = LB'((32'd1 << HSIZE) - 32'd1);
  assign acc_err = !size_legal(HSIZE, LB)
                || ((HADDR[LB-1:0] & size_off_mask) != '0)
                || (32'(HADDR[AWIDTH-1:LB]) >= DEPTH)
                || (CFG_ERR_EN && (((HADDR ^ CFG_ERR_BASE) & CFG_ERR_MASK) == '0));

  assign idx_in = HADDR[LB +: IW];
  assign idx_q  = addr_q[LB +: IW];
  assign rd_idx = (state_q == StWait) ? idx_q : idx_in;

  // A pending write is dropped if reset lands on its closing edge.
  assign ram_we = (state_q == StData) && write_q && !HRESET;
  assign be     = NB'(lane_mask(size_q, 3'(addr_q[LB-1:0])));

  ahb_slave_mem_ram #(
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk_i  (HCLK),
    .we_i   (ram_we),
    .be_i   (be),
    .waddr_i(idx_q),
    .wdata_i(HWDATA),
    .raddr_i(rd_idx),
    .rdata_o(mem_rdata)
  );

  // Merge bytes committing this edge so a pipelined read never sees stale data.
  always_comb begin
    rd_word = mem_rdata;
    for (int b = 0; b < NB; b++) begin
      if (ram_we && (idx_q == rd_idx) && be[b]) begin
        rd_word[8*b +: 8] = HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    wait_d  = wait_q;
    load_rd = 1'b0;
    unique case (state_q)
      StIdle, StData: begin
        state_d = StIdle;
        if (accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          size_d  = HSIZE;
          wait_d  = CFG_WAIT;
          if (acc_err) begin
            state_d = StErr1;
          end else if (CFG_WAIT != '0) begin
            state_d = StWait;
          end else begin
            state_d = StData;
            load_rd = !HWRITE;
          end
        end
      end
      StWait: begin
        wait_d = wait_q - WWIDTH'(1);
        if (wait_q == WWIDTH'(1)) begin
          state_d = StData;
          load_rd = !write_q;
        end
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hrdata_d = load_rd ? rd_word : hrdata_q;
    acc_d    = acc_q;
    err_d    = err_q;
    if (state_q == StData && acc_q != '1) begin
      acc_d = acc_q + CNT_WIDTH'(1);
    end
    if (state_q == StErr2 && err_q != '1) begin
      err_d = err_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      wait_q   <= '0;
      hrdata_q <= '0;
      acc_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      wait_q   <= wait_d;
      hrdata_q <= hrdata_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
    end
  end

  assign HREADYOUT = !(state_q == StWait || state_q == StErr1);
  assign HRESP     = (state_q == StErr1 || state_q == StErr2) ? HrespError : HrespOkay;
  assign HRDATA    = hrdata_q;
  assign ACC_COUNT = acc_q;
  assign ERR_COUNT = err_q;

endmodule

// File: tb/tb_ahb_slave_mem_model.sv
// Scoreboard bench: the driver queues the expected response of each transfer, the monitor
// pops and checks it when the data phase completes.
module tb_ahb_slave_mem_model;
  import ahb_slave_mem_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [11:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [3:0]  CFG_WAIT;
  logic        CFG_ERR_EN;
  logic [11:0] CFG_ERR_BASE;
  logic [11:0] CFG_ERR_MASK;
  logic [15:0] ACC_COUNT;
  logic [15:0] ERR_COUNT;

  assign HREADY = HREADYOUT;

  ahb_slave_mem_model #(
    .AWIDTH   (12),
    .DWIDTH   (32),
    .DEPTH    (512),
    .WWIDTH   (4),
    .CNT_WIDTH(16)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HMASTLOCK   (HMASTLOCK),
    .HPROT       (HPROT),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .CFG_WAIT    (CFG_WAIT),
    .CFG_ERR_EN  (CFG_ERR_EN),
    .CFG_ERR_BASE(CFG_ERR_BASE),
    .CFG_ERR_MASK(CFG_ERR_MASK),
    .ACC_COUNT   (ACC_COUNT),
    .ERR_COUNT   (ERR_COUNT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [11:0] addr;
    logic        rd;
    logic        err;
    int          waits;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: tracks data phases from bus activity, pops one expectation per completion.
  logic dp = 1'b0;
  logic low_resp;
  int   lows;
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESET === 1'b1) begin
        dp = 1'b0;
      end else begin
        if (dp) begin
          if (!HREADYOUT) begin
            lows++;
            low_resp = low_resp | HRESP;
          end else begin
            dp = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_completion", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("waits@%h", e.addr), 32'(lows), 32'(e.waits));
              check($sformatf("resp@%h", e.addr), {30'd0, HRESP, low_resp},
                    e.err ? 32'd3 : 32'd0);
              if (e.rd && !e.err) check($sformatf("rdata@%h", e.addr), HRDATA, e.data);
            end
          end
        end
        if (HSEL && HREADY && HTRANS[1]) begin
          dp       = 1'b1;
          lows     = 0;
          low_resp = 1'b0;
        end
      end
    end
  end

  // Waits for the address phase to be accepted, leaving time just after that edge.
  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge HCLK);
      if (HREADY) break;
      n++;
      if (n > 40) begin
        check("timeout_hready", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic xfer(input logic [11:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input logic err, input logic [31:0] rexp);
    exp_t e;
    HSEL   = 1'b1;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
    HTRANS = HtransNonseq;
    e.addr = a; e.rd = !w; e.err = err; e.data = rexp;
    e.waits = err ? 1 : int'(CFG_WAIT);
    exp_q.push_back(e);
    wait_accept();
    HSEL   = 1'b0;
    HTRANS = HtransIdle;
    HWDATA = wd;
  endtask

  // Let the outstanding data phase finish, then n idle cycles.
  task automatic idle(input int n);
    HSEL   = 1'b0;
    HTRANS = HtransIdle;
    wait_accept();
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = HtransIdle;
    HSIZE = 3'd2; HBURST = '0; HMASTLOCK = 1'b0; HPROT = 4'h3; HWDATA = '0;
    CFG_WAIT = '0; CFG_ERR_EN = 1'b0; CFG_ERR_BASE = '0; CFG_ERR_MASK = '0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hresp", 32'(HRESP), 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_acc", 32'(ACC_COUNT), 32'd0);
    check("rst_err", 32'(ERR_COUNT), 32'd0);

    // BUSY while idle: zero-wait OKAY, not accepted.
    HSEL = 1'b1; HTRANS = HtransBusy; HADDR = 12'h010;
    @(negedge HCLK);
    check("busy_ready", {31'd0, HREADYOUT}, 32'd1);
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = HtransIdle;
    check("busy_no_accept", {30'd0, HREADYOUT, HRESP}, 32'd2);

    // Zero-wait write then back-to-back read.
    xfer(12'h010, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer(12'h010, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
    idle(1);
    check("acc_after_rw", 32'(ACC_COUNT), 32'd2);

    // Three wait states on write and read.
    CFG_WAIT = 4'd3;
    xfer(12'h020, 1'b1, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0);
    xfer(12'h020, 1'b0, 3'd2, 32'h0, 1'b0, 32'hCAFEF00D);
    idle(1);

    // Byte and halfword lanes with forwarding into a back-to-back read.
    CFG_WAIT = 4'd0;
    xfer(12'h000, 1'b1, 3'd2, 32'h11223344, 1'b0, 32'h0);
    xfer(12'h002, 1'b1, 3'd0, 32'h00AA0000, 1'b0, 32'h0);
    xfer(12'h000, 1'b0, 3'd2, 32'h0, 1'b0, 32'h11AA3344);
    xfer(12'h004, 1'b1, 3'd2, 32'h55667788, 1'b0, 32'h0);
    xfer(12'h006, 1'b1, 3'd1, 32'h12340000, 1'b0, 32'h0);
    xfer(12'h004, 1'b0, 3'd2, 32'h0, 1'b0, 32'h12347788);
    idle(1);

    // Error-range injection leaves memory untouched.
    xfer(12'h104, 1'b1, 3'd2, 32'h0BADF00D, 1'b0, 32'h0);
    idle(1);
    CFG_ERR_EN = 1'b1; CFG_ERR_BASE = 12'h100; CFG_ERR_MASK = 12'hF00;
    xfer(12'h104, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
    idle(1);
    xfer(12'h010, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
    idle(1);
    CFG_ERR_EN = 1'b0;
    xfer(12'h104, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0BADF00D);
    idle(1);
    check("err_after_inject", 32'(ERR_COUNT), 32'd1);

    // Illegal size, misaligned halfword, word index == DEPTH.
    xfer(12'h000, 1'b0, 3'd3, 32'h0, 1'b1, 32'h0);
    idle(1);
    xfer(12'h001, 1'b0, 3'd1, 32'h0, 1'b1, 32'h0);
    idle(1);
    xfer(12'h800, 1'b1, 3'd2, 32'h01020304, 1'b1, 32'h0);
    idle(1);
    check("err_after_illegal", 32'(ERR_COUNT), 32'd4);

    // Reset in the second wait cycle of a write.
    xfer(12'h030, 1'b1, 3'd2, 32'h13579BDF, 1'b0, 32'h0);
    idle(1);
    CFG_WAIT = 4'd5;
    HSEL = 1'b1; HADDR = 12'h030; HWRITE = 1'b1; HSIZE = 3'd2; HTRANS = HtransNonseq;
    @(posedge HCLK);
    #1;
    HSEL = 1'b0; HTRANS = HtransIdle; HWDATA = 32'hFFFFFFFF;
    @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    check("midrst_ready_resp", {30'd0, HREADYOUT, HRESP}, 32'd2);
    check("midrst_acc", 32'(ACC_COUNT), 32'd0);
    check("midrst_err", 32'(ERR_COUNT), 32'd0);
    CFG_WAIT = 4'd0;
    xfer(12'h030, 1'b0, 3'd2, 32'h0, 1'b0, 32'h13579BDF);
    idle(1);
    check("acc_after_midrst", 32'(ACC_COUNT), 32'd1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(posedge HCLK);
        n++;
      end
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
